fb_serial_sequencer: RTL and testbench
======================================

Name: fb_serial_sequencer

Overview:
Central sequencer for the 16-band serial filter bank. It accepts input samples through a valid/ready handshake and strobes the shared input delay pipeline once per accepted sample. It then steps every band filter's serial MAC through SERIAL_FACTOR tap phases and commands a common output latch. This replaces per-filter phase generation with one shared phase source, so all bands advance in lockstep.

Parameters:
SERIAL_FACTOR, 60, MAC phases per sample (one tap pair per phase); legal range 2..255.
TAP_W, 8, width of tap_sel; must satisfy 2**TAP_W >= SERIAL_FACTOR.
FRAME_W, 16, width of frame counter.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
clk_enable  in  1  global enable; when 0, sequencer freezes
flush  in  1  synchronous abort/clear request
in_valid  in  1  input sample present
in_ready  out  1  sequencer can accept a sample (combinational)
shift_en  out  1  advance shared delay pipeline by one sample (combinational, = accept)
pipe_clr  out  1  clear shared delay pipeline (registered pulse)
tap_sel  out  TAP_W  current MAC phase index to all band filters
acc_clr  out  1  band accumulators load (not add) this phase
acc_en  out  1  band accumulators active this phase
out_latch  out  1  band filters capture accumulator to filter_out
out_valid  out  1  one-cycle pulse: all 16 filter_out updated
busy  out  1  state != IDLE
frame_cnt  out  FRAME_W  count of completed frames, wraps

Behaviour:
- States: IDLE, MAC, DUMP. Reset (reset==0): state=IDLE, tap_sel=0, acc_clr=0, acc_en=0, out_latch=0, out_valid=0, pipe_clr=0, frame_cnt=0, busy=0.
- in_ready = clk_enable & (state==IDLE) & ~flush.
- Accept = in_valid & in_ready. shift_en = accept, in the same cycle. IDLE->MAC on accept.
- MAC: tap_sel counts 0..SERIAL_FACTOR-1, one per enabled cycle. acc_en=1 throughout MAC. acc_clr=1 only while tap_sel==0. MAC->DUMP after tap_sel==SERIAL_FACTOR-1.
- DUMP lasts one cycle: out_latch=1, then DUMP->IDLE. out_valid pulses one cycle after DUMP (the first IDLE cycle), and frame_cnt increments in that same cycle (wraps at 2**FRAME_W).
- All outputs except in_ready and shift_en are registered, or decoded only from registered state.
- Timeline, accept at cycle T: tap_sel=0 with acc_clr at T+1; tap_sel=SF-1 at T+SF; out_latch at T+SF+1; out_valid and in_ready=1 at T+SF+2. Minimum sample period is SF+2 cycles.
- clk_enable=0: state, tap_sel and frame_cnt hold. acc_en, acc_clr, out_latch, shift_en and out_valid are forced 0. If an out_valid was due, it is deferred to the next enabled cycle and is not lost. Resuming continues at the held tap_sel.
- flush=1 (sampled with clk_enable=1), any state: next state is IDLE and tap_sel=0. pipe_clr pulses for 1 cycle. No out_latch or out_valid for the aborted frame. frame_cnt holds. flush has priority over accept and over the DUMP exit.
- flush while clk_enable=0 is ignored.
- in_valid held high while busy: no accept and no side effects. The sample is taken at the first IDLE cycle.
- Async reset mid-MAC: all outputs return to reset values immediately. No out_valid is generated for the partial frame.

Optional Feature:
Macro FB_SEQ_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], reset 0. It increments (saturating at 16'hFFFF) on every cycle with clk_enable=1, in_valid=1 and in_ready=0. It clears on flush.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, in_valid pulse at cycle 5 (SF=60) -> shift_en=1 at 5; acc_clr & tap_sel=0 at 6; tap_sel=59 at 65; out_latch at 66; out_valid=1, frame_cnt=1, in_ready=1 at 67.
- in_valid held high continuously for 3 frames -> accepts at cycles 5, 67, 129; frame_cnt=3 after cycle 191; never two shift_en within 62 cycles.
- clk_enable=0 for 10 cycles while tap_sel=20 -> tap_sel stays 20 and acc_en=0 for those 10 cycles; out_valid is delayed exactly 10 cycles versus the baseline.
- flush at tap_sel=30 -> pipe_clr pulse next cycle, state IDLE, tap_sel=0, no out_latch or out_valid, frame_cnt unchanged, in_ready=1.
- reset driven 0 at tap_sel=45, released 3 cycles later -> all outputs at reset values, frame_cnt=0; next sample runs the full 62-cycle frame.
- (FB_SEQ_STALL_CNT_EN) in_valid held high for 2 frames from cycle 5 -> stall_cnt=122 at end of second frame; flush -> stall_cnt=0.

Source files
------------

// File: rtl/fb_serial_sequencer.sv
// Shared phase sequencer for the 16-band serial filter bank: accept, MAC phases, dump.
// Optional FB_SEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module fb_serial_sequencer #(
    parameter int SERIAL_FACTOR = 60,
    parameter int TAP_W         = 8,
    parameter int FRAME_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               shift_en,
    output logic               pipe_clr,
    output logic [TAP_W-1:0]   tap_sel,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               out_latch,
    output logic               out_valid,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt
`ifdef FB_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(SERIAL_FACTOR - 1);

    state_t             state;
    state_t             state_next;
    logic [TAP_W-1:0]   tap_next;
    logic [FRAME_W-1:0] frame_next;
    logic               valid_pend;
    logic               valid_pend_next;
    logic               accept;

    assign in_ready  = clk_enable & (state == IDLE) & ~flush;
    assign accept    = in_valid & in_ready;
    assign shift_en  = accept;
    assign busy      = (state != IDLE);
    assign acc_en    = clk_enable & (state == MAC);
    assign acc_clr   = clk_enable & (state == MAC) & (tap_sel == '0);
    assign out_latch = clk_enable & (state == DUMP) & ~flush;
    // valid_pend survives disabled cycles so a completed frame is never dropped
    assign out_valid = clk_enable & valid_pend;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tap_sel    <= '0;
            frame_cnt  <= '0;
            valid_pend <= 1'b0;
            pipe_clr   <= 1'b0;
        end else begin
            state      <= state_next;
            tap_sel    <= tap_next;
            frame_cnt  <= frame_next;
            valid_pend <= valid_pend_next;
            pipe_clr   <= clk_enable & flush;
        end
    end

    always_comb begin
        state_next      = state;
        tap_next        = tap_sel;
        frame_next      = frame_cnt;
        valid_pend_next = valid_pend;
        if (clk_enable) begin
            valid_pend_next = 1'b0;
            if (flush) begin
                state_next = IDLE;
                tap_next   = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state_next = MAC;
                            tap_next   = '0;
                        end
                    end
                    MAC: begin
                        if (tap_sel == LAST_TAP) begin
                            state_next = DUMP;
                            tap_next   = '0;
                        end else begin
                            tap_next = tap_sel + 1'b1;
                        end
                    end
                    DUMP: begin
                        state_next      = IDLE;
                        valid_pend_next = 1'b1;
                        frame_next      = frame_cnt + 1'b1;
                    end
                    default: begin
                        state_next = IDLE;
                        tap_next   = '0;
                    end
                endcase
            end
        end
    end

`ifdef FB_SEQ_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (clk_enable & flush) begin
            stall_cnt <= '0;
        end else if (clk_enable & in_valid & ~in_ready & (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_serial_sequencer.sv
// Directed testbench for fb_serial_sequencer (SERIAL_FACTOR=60): vector table plus corner sequences.
module tb_fb_serial_sequencer;

    typedef struct packed {
        logic        in_ready;
        logic        shift_en;
        logic        pipe_clr;
        logic        acc_clr;
        logic        acc_en;
        logic        out_latch;
        logic        out_valid;
        logic        busy;
        logic [7:0]  tap_sel;
        logic [15:0] frame_cnt;
    } outs_t;

    typedef struct {
        logic  in_valid;
        logic  clk_enable;
        logic  flush;
        int    adv;
        outs_t exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        clk_enable;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        shift_en;
    logic        pipe_clr;
    logic [7:0]  tap_sel;
    logic        acc_clr;
    logic        acc_en;
    logic        out_latch;
    logic        out_valid;
    logic        busy;
    logic [15:0] frame_cnt;
`ifdef FB_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[13];

    fb_serial_sequencer #(
        .SERIAL_FACTOR(60),
        .TAP_W(8),
        .FRAME_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clk_enable(clk_enable),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .shift_en(shift_en),
        .pipe_clr(pipe_clr),
        .tap_sel(tap_sel),
        .acc_clr(acc_clr),
        .acc_en(acc_en),
        .out_latch(out_latch),
        .out_valid(out_valid),
        .busy(busy),
        .frame_cnt(frame_cnt)
`ifdef FB_SEQ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outs_t mkOut(logic ir, logic se, logic pc, logic ac, logic ae,
                                    logic ol, logic ov, logic bz, logic [7:0] tap,
                                    logic [15:0] fc);
        outs_t o;
        o = '{ir, se, pc, ac, ae, ol, ov, bz, tap, fc};
        return o;
    endfunction

    function automatic vec_t mkVec(logic iv, logic en, logic fl, int adv, outs_t o);
        vec_t v;
        v.in_valid   = iv;
        v.clk_enable = en;
        v.flush      = fl;
        v.adv        = adv;
        v.exp        = o;
        return v;
    endfunction

    function automatic outs_t gotOut();
        return mkOut(in_ready, shift_en, pipe_clr, acc_clr, acc_en, out_latch,
                     out_valid, busy, tap_sel, frame_cnt);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic en, input logic fl);
        in_valid   = iv;
        clk_enable = en;
        flush      = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t got;
        got = gotOut();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkVal(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        int n_acc;
        int last;
        int bad;
        int ov_cnt;
        int k;

        reset      = 1'b0;
        clk_enable = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        repeat (3) tick();
        reset = 1'b1;

        // cycle numbering starts at the first cycle after reset release
        vecs[0]  = mkVec(0, 1, 0, 5,  mkOut(1, 0, 0, 0, 0, 0, 0, 0, 8'd0,  16'd0));
        vecs[1]  = mkVec(1, 1, 0, 1,  mkOut(1, 1, 0, 0, 0, 0, 0, 0, 8'd0,  16'd0));
        vecs[2]  = mkVec(0, 1, 0, 1,  mkOut(0, 0, 0, 1, 1, 0, 0, 1, 8'd0,  16'd0));
        vecs[3]  = mkVec(0, 1, 0, 1,  mkOut(0, 0, 0, 0, 1, 0, 0, 1, 8'd1,  16'd0));
        vecs[4]  = mkVec(1, 1, 0, 1,  mkOut(0, 0, 0, 0, 1, 0, 0, 1, 8'd2,  16'd0));
        vecs[5]  = mkVec(0, 1, 0, 56, mkOut(0, 0, 0, 0, 1, 0, 0, 1, 8'd3,  16'd0));
        vecs[6]  = mkVec(0, 1, 0, 1,  mkOut(0, 0, 0, 0, 1, 0, 0, 1, 8'd59, 16'd0));
        vecs[7]  = mkVec(0, 1, 0, 1,  mkOut(0, 0, 0, 0, 0, 1, 0, 1, 8'd0,  16'd0));
        vecs[8]  = mkVec(0, 1, 0, 1,  mkOut(1, 0, 0, 0, 0, 0, 1, 0, 8'd0,  16'd1));
        vecs[9]  = mkVec(1, 1, 1, 1,  mkOut(0, 0, 0, 0, 0, 0, 0, 0, 8'd0,  16'd1));
        vecs[10] = mkVec(0, 1, 0, 1,  mkOut(1, 0, 1, 0, 0, 0, 0, 0, 8'd0,  16'd1));
        vecs[11] = mkVec(1, 0, 0, 1,  mkOut(0, 0, 0, 0, 0, 0, 0, 0, 8'd0,  16'd1));
        vecs[12] = mkVec(0, 1, 0, 0,  mkOut(1, 0, 0, 0, 0, 0, 0, 0, 8'd0,  16'd1));

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].clk_enable, vecs[i].flush);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
            repeat (vecs[i].adv) tick();
        end

        // in_valid held for three frames: accepts exactly 62 cycles apart
        n_acc  = 0;
        last   = 0;
        bad    = 0;
        ov_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(n_acc < 3, 1, 0);
            if (shift_en) begin
                if (n_acc > 0 && (c - last) != 62) bad++;
                last = c;
                n_acc++;
            end
            if (out_valid) ov_cnt++;
            tick();
        end
        checkVal("held_accepts", n_acc, 3);
        checkVal("held_gap", bad, 0);
        checkVal("held_out_valid", ov_cnt, 3);
        checkVal("held_frame_cnt", frame_cnt, 4);

        // clk_enable low for 10 cycles at tap 20 delays out_valid by 10
        applyStimulus(1, 1, 0);
        checkVal("stall_accept", shift_en, 1);
        tick();
        applyStimulus(0, 1, 0);
        repeat (20) tick();
        checkVal("stall_tap20", tap_sel, 20);
        bad = 0;
        repeat (10) begin
            applyStimulus(0, 0, 0);
            if (tap_sel != 8'd20 || acc_en || acc_clr || !busy) bad++;
            tick();
        end
        checkVal("stall_hold", bad, 0);
        applyStimulus(0, 1, 0);
        checkVal("resume_tap", tap_sel, 20);
        checkVal("resume_acc_en", acc_en, 1);
        for (k = 0; k < 100; k++) begin
            applyStimulus(0, 1, 0);
            if (out_valid) break;
            tick();
        end
        checkVal("stall_ov_delay", k, 41);
        checkVal("stall_frame_cnt", frame_cnt, 5);
        tick();

        // out_valid due while disabled is deferred, not lost
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        repeat (60) tick();
        checkVal("defer_latch", out_latch, 1);
        tick();
        bad = 0;
        repeat (3) begin
            applyStimulus(0, 0, 0);
            if (out_valid || out_latch) bad++;
            tick();
        end
        checkVal("defer_forced_low", bad, 0);
        applyStimulus(0, 1, 0);
        checkVal("defer_ov", out_valid, 1);
        tick();
        checkVal("defer_ov_once", out_valid, 0);
        checkVal("defer_frame_cnt", frame_cnt, 6);

        // flush at tap 30 aborts the frame
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        repeat (30) tick();
        checkVal("flush_tap30", tap_sel, 30);
        applyStimulus(0, 1, 1);
        tick();
        applyStimulus(0, 1, 0);
        checkOutput("flush_next", mkOut(1, 0, 1, 0, 0, 0, 0, 0, 8'd0, 16'd6));
        bad = 0;
        repeat (70) begin
            tick();
            applyStimulus(0, 1, 0);
            if (out_latch || out_valid || pipe_clr || busy) bad++;
        end
        checkVal("flush_quiet", bad, 0);
        checkVal("flush_frame_cnt", frame_cnt, 6);

        // flush with clk_enable low is ignored
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        repeat (5) tick();
        applyStimulus(0, 0, 1);
        tick();
        applyStimulus(0, 1, 0);
        checkOutput("flush_disabled", mkOut(0, 0, 0, 0, 1, 0, 0, 1, 8'd5, 16'd6));
        applyStimulus(0, 1, 1);
        tick();
        applyStimulus(0, 1, 0);
        checkOutput("flush_cleanup", mkOut(1, 0, 1, 0, 0, 0, 0, 0, 8'd0, 16'd6));
        tick();

        // async reset at tap 45, then a full frame afterwards
        applyStimulus(1, 1, 0);
        tick();
        applyStimulus(0, 1, 0);
        repeat (45) tick();
        checkVal("rst_tap45", tap_sel, 45);
        reset = 1'b0;
        #1;
        checkOutput("rst_immediate", mkOut(1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 16'd0));
        repeat (3) tick();
        checkOutput("rst_held", mkOut(1, 0, 0, 0, 0, 0, 0, 0, 8'd0, 16'd0));
        reset = 1'b1;
        applyStimulus(1, 1, 0);
        checkVal("rst_accept", shift_en, 1);
        tick();
        applyStimulus(0, 1, 0);
        for (k = 1; k < 100; k++) begin
            if (out_valid) break;
            tick();
        end
        checkVal("rst_frame_len", k, 62);
        checkVal("rst_frame_cnt", frame_cnt, 1);
        tick();

        // two back-to-back frames with in_valid held high
        applyStimulus(0, 1, 1);
        tick();
        for (int c = 0; c < 124; c++) begin
            applyStimulus(1, 1, 0);
            tick();
        end
        applyStimulus(0, 1, 0);
        checkVal("two_frame_ov", out_valid, 1);
        checkVal("two_frame_cnt", frame_cnt, 3);
`ifdef FB_SEQ_STALL_CNT_EN
        checkVal("stall_cnt_122", stall_cnt, 122);
`endif
        applyStimulus(0, 1, 1);
        tick();
        applyStimulus(0, 1, 0);
        checkVal("final_pipe_clr", pipe_clr, 1);
`ifdef FB_SEQ_STALL_CNT_EN
        checkVal("stall_cnt_flush", stall_cnt, 0);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
